seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Parametrised multiplexed seven-segment driver. It succeeds the fixed 4-digit display block with these additions:
- configurable digit count and refresh rate;
- anti-ghosting dead time between digits;
- PWM brightness;
- decimal points;
- leading-zero blanking;
- tear-free value updates latched at frame boundaries.

It sits between CPU-visible debug/status registers and the board's common-anode display pins.

## Interface
- DIGITS, 4: number of digits, 1..16.
- DIV, 100000: clk cycles per digit slot. Must satisfy DIV >= GAP + 2.
- GAP, 64: dead-time cycles at the start of each slot, during which all anodes are off. Must be >= 1.
- BRIGHT_W, 4: brightness field width.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- value  in  4*DIGITS  hex nibbles; nibble i drives digit i, and digit 0 is the rightmost digit.
- dp_in  in  DIGITS  decimal point request per digit, 1 = lit.
- load  in  1  strobe that captures value/dp_in for display.
- lz_en  in  1  enables leading-zero blanking.
- brightness  in  BRIGHT_W  duty level; all-ones means always on while showing.
- out  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp  out  1  decimal point, active low.
- an  out  DIGITS  digit enables, active low.
- frame_start  out  1  one-cycle pulse at the start of each frame.

## Operation
- **Prescaler and digit index**
  - Prescaler p counts 0..DIV-1 and wraps.
  - On each wrap, digit index idx increments mod DIGITS.
- **Slot phases**
  - GAP phase (p < GAP): an all ones, out = 7'h7F, dp = 1.
  - SHOW phase (p >= GAP): an[idx] is low when the PWM condition holds; all other an bits are high.
- **PWM**
  - q = (p - GAP) mod 2^BRIGHT_W.
  - The digit is enabled when brightness is all ones, or when q < brightness.
  - brightness = 0 keeps the display dark.
- **Font**
  - Standard hex font, active low. Examples: 0 = 7'b1000000, 1 = 7'b1111001, 4 = 7'b0011001, 8 = 7'b0000000, A = 7'b0001000, F = 7'b0001110.
- **Registers**
  - active holds the displayed nibbles and dp bits.
  - pending holds the last loaded nibbles and dp bits, plus a flag pend_v.
  - load captures value/dp_in into pending and sets pend_v.
- **Frame-end update** (p == DIV-1 and idx == DIGITS-1):
  - if load is high that cycle, active takes value/dp_in directly;
  - else if pend_v is set, active takes pending;
  - pend_v clears in either case.
- **Leading-zero blanking**
  - With lz_en = 1, digit i > 0 is blanked when nibbles i..DIGITS-1 of active are all zero and dp bits i..DIGITS-1 are all zero.
  - A blanked digit has its anode forced high for the whole slot.
  - Digit 0 is never blanked.
- **Outputs**
  - out, dp, an and frame_start are registered, one cycle after the p/idx state that produces them.
  - frame_start pulses in the cycle after p == 0 and idx == 0.
- **Reset**
  - p = 0, idx = 0, active = 0, pending = 0, pend_v = 0.
  - out = 7'h7F, dp = 1, an = all ones, frame_start = 0.
- **Brightness and lz_en** are used live, not latched.

## Timing
- Slot length is DIV cycles; frame length is DIGITS*DIV cycles.
- After rst_n deasserts, the first clk edge holds p = 0, idx = 0. Outputs reflect that state one edge later, so frame_start is high during the second post-reset cycle.
- Each output follows the p/idx state with exactly one cycle of latency.
- Value latency: a load is displayed from the first frame that starts after the load. Worst case is one frame plus one cycle.
- Multiple loads within one frame: the last one wins.
- Load at the frame-end cycle is applied to the next frame.
- Asynchronous reset mid-slot drives all outputs to their reset values immediately and discards pending.
- DIGITS = 1: idx stays 0 and frame_start pulses every slot.

## Test plan
Use DIGITS=4, DIV=16, GAP=2, BRIGHT_W=2 unless stated.
- **Reset and first-frame display**
  - Stimulus: reset, then brightness = 3, load value = 16'h1234 in cycle 5.
  - Required: frame 0 shows 0 on all digits. From frame 1, slot 0 gives an = 4'b1110 and out = 7'b0011001 for cycles p = 2..15, with an = 4'hF for p = 0..1.
- **Brightness PWM**
  - Stimulus: brightness = 1.
  - Required: an[idx] is low only when q == 0, i.e. p = 2, 6, 10, 14.
  - Stimulus: brightness = 0.
  - Required: an stays 4'hF.
- **Leading-zero blanking**
  - Stimulus: value = 16'h0050, lz_en = 1.
  - Required: digits 3 and 2 have an high for the whole slot; digit 1 shows 5; digit 0 shows 0.
  - Stimulus: set dp_in[3] = 1.
  - Required: digits 2 and 3 are shown, with dp low on digit 3.
- **Tear-free update**
  - Stimulus: loads of 16'hAAAA then 16'hBBBB mid-frame; a separate load at the frame-end cycle.
  - Required: the next frame shows only B. The frame-end load is visible at the very next frame.
- **Reset mid-operation and single-digit case**
  - Stimulus: assert rst_n low at p = 7, idx = 2.
  - Required: outputs go to reset values asynchronously; after release, frame_start pulses in the second cycle.
  - Stimulus: DIGITS = 1.
  - Required: frame_start pulses every 16 cycles.

Source files
------------

// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle for seven_seg_scanner.
//   master : the register block driving what to show (value, dp_in, load,
//            lz_en, brightness) and observing the pins.
//   slave  : the scanner itself, producing the active-low pin levels
//            (out, dp, an) and the frame_start pulse.
interface seven_seg_scanner_if #(
  parameter int DIGITS   = 4,
  parameter int BRIGHT_W = 4
);
  logic [4*DIGITS-1:0] value;        // nibble i -> digit i, digit 0 rightmost
  logic [DIGITS-1:0]   dp_in;        // decimal point request, 1 = lit
  logic                load;         // capture value/dp_in
  logic                lz_en;        // leading-zero blanking enable
  logic [BRIGHT_W-1:0] brightness;   // duty level, all ones = always on
  logic [6:0]          out;          // segments {g,f,e,d,c,b,a}, active low
  logic                dp;           // decimal point, active low
  logic [DIGITS-1:0]   an;           // digit enables, active low
  logic                frame_start;  // one-cycle pulse per frame

  modport master (
    output value, dp_in, load, lz_en, brightness,
    input  out, dp, an, frame_start
  );

  modport slave (
    input  value, dp_in, load, lz_en, brightness,
    output out, dp, an, frame_start
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode seven-segment driver.
// Each digit owns a slot of DIV clocks: the first GAP clocks are dead time
// with every anode off, the rest show the digit gated by a PWM duty cycle.
// Displayed data only changes at the frame boundary, so a frame never mixes
// old and new digits.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - seven_seg_scanner_if.slave (value/dp_in/load/lz_en/brightness in,
//           out/dp/an/frame_start out, all outputs registered)
module seven_seg_scanner #(
  parameter int DIGITS   = 4,
  parameter int DIV      = 100000,
  parameter int GAP      = 64,
  parameter int BRIGHT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  seven_seg_scanner_if.slave bus
);

  localparam int P_W   = $clog2(DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [P_W-1:0]      p;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] active_val;
  logic [DIGITS-1:0]   active_dp;
  logic [4*DIGITS-1:0] pend_val;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_v;

  logic                wrap;
  logic                frame_end;
  logic                in_gap;
  logic                pwm_on;
  logic                lit;
  logic [BRIGHT_W-1:0] q;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic [DIGITS-1:0]   blank;
  logic [6:0]          out_next;
  logic                dp_next;
  logic [DIGITS-1:0]   an_next;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: hex_font = 7'b1000000;
      4'h1: hex_font = 7'b1111001;
      4'h2: hex_font = 7'b0100100;
      4'h3: hex_font = 7'b0110000;
      4'h4: hex_font = 7'b0011001;
      4'h5: hex_font = 7'b0010010;
      4'h6: hex_font = 7'b0000010;
      4'h7: hex_font = 7'b1111000;
      4'h8: hex_font = 7'b0000000;
      4'h9: hex_font = 7'b0010000;
      4'hA: hex_font = 7'b0001000;
      4'hB: hex_font = 7'b0000011;
      4'hC: hex_font = 7'b1000110;
      4'hD: hex_font = 7'b0100001;
      4'hE: hex_font = 7'b0000110;
      default: hex_font = 7'b0001110;
    endcase
  endfunction

  assign wrap      = (p == P_W'(DIV - 1));
  assign frame_end = wrap && (idx == IDX_W'(DIGITS - 1));
  assign in_gap    = (p < P_W'(GAP));

  // PWM phase restarts at the first SHOW cycle of every slot.
  assign q      = BRIGHT_W'(32'(p) - 32'(GAP));
  assign pwm_on = (bus.brightness == '1) || (q < bus.brightness);

  // Shift-and-truncate selects keep the digit mux legal for any DIGITS,
  // including 1 where idx is a dummy bit.
  assign cur_nib   = 4'(active_val >> (4 * idx));
  assign cur_dp    = 1'(active_dp >> idx);
  assign cur_blank = 1'(blank >> idx);

  // A digit is blank when it and everything to its left is zero with no dp.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and a latch is never inferred.
    logic tail_zero;
    blank     = '0;
    tail_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      // NOTE: blocking '=' here because tail_zero must carry the value just
      // computed into the next iteration of the same evaluation.
      tail_zero = tail_zero && (4'(active_val >> (4 * i)) == 4'h0)
                  && !active_dp[i];
      blank[i]  = tail_zero;
    end
  end

  assign lit      = !in_gap && pwm_on && !(bus.lz_en && cur_blank);
  assign an_next  = lit ? ~(DIGITS'(1) << idx) : '1;
  assign out_next = in_gap ? 7'h7F : hex_font(cur_nib);
  assign dp_next  = in_gap ? 1'b1 : ~cur_dp;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the display and pending registers are reset too, not just the
    // counters: frame 0 must show zeros and a reset must drop any queued load.
    if (!rst_n) begin
      p               <= '0;
      idx             <= '0;
      active_val      <= '0;
      active_dp       <= '0;
      pend_val        <= '0;
      pend_dp         <= '0;
      pend_v          <= 1'b0;
      bus.out         <= 7'h7F;
      bus.dp          <= 1'b1;
      bus.an          <= '1;
      bus.frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking '<=' for all state so every register samples the
      // pre-edge values regardless of statement order.
      bus.out         <= out_next;
      bus.dp          <= dp_next;
      bus.an          <= an_next;
      bus.frame_start <= (p == '0) && (idx == '0);

      if (wrap) begin
        p   <= '0;
        idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        p <= p + P_W'(1);
      end

      // A load coinciding with the frame end bypasses pending so it still
      // makes the very next frame.
      if (frame_end) begin
        if (bus.load) begin
          active_val <= bus.value;
          active_dp  <= bus.dp_in;
        end else if (pend_v) begin
          active_val <= pend_val;
          active_dp  <= pend_dp;
        end
        pend_v <= 1'b0;
      end else if (bus.load) begin
        pend_val <= bus.value;
        pend_dp  <= bus.dp_in;
        pend_v   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: a 4-digit instance (DIV=16, GAP=2,
// BRIGHT_W=2) and a 1-digit instance sharing clock and reset.
// State t is the number of rising edges since reset release; the outputs
// seen at the negedge while the counter reads t+1 belong to state t, with
// p = t % 16, idx = (t / 16) % 4, frame = t / 64.
module tb_seven_seg_scanner;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_bad;

  seven_seg_scanner_if #(.DIGITS(4), .BRIGHT_W(2)) bus  ();
  seven_seg_scanner_if #(.DIGITS(1), .BRIGHT_W(2)) bus1 ();

  seven_seg_scanner #(.DIGITS(4), .DIV(16), .GAP(2), .BRIGHT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  seven_seg_scanner #(.DIGITS(1), .DIV(16), .GAP(2), .BRIGHT_W(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to the negedge where the bench counter reads t.
  task automatic at_state(input int t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != t) check("sync", cyc, t);
  endtask

  // Outputs for state t become visible one edge later.
  task automatic see(input int t);
    at_state(t + 1);
  endtask

  task automatic load_at(input int t, input logic [15:0] v,
                         input logic [3:0] d);
    at_state(t);
    bus.value = v;
    bus.dp_in = d;
    bus.load  = 1'b1;
    at_state(t + 1);
    bus.load  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.value = 16'h0; bus.dp_in = 4'h0; bus.load = 1'b0;
    bus.lz_en = 1'b0;  bus.brightness = 2'd3;
    bus1.value = 4'h8; bus1.dp_in = 1'b0; bus1.load = 1'b0;
    bus1.lz_en = 1'b0; bus1.brightness = 2'd3;

    // Reset values, then release away from the clock edge.
    repeat (3) @(negedge clk);
    check("rst_out", 32'(bus.out), 32'h7F);
    check("rst_dp",  32'(bus.dp), 32'h1);
    check("rst_an",  32'(bus.an), 32'hF);
    check("rst_fs",  32'(bus.frame_start), 32'h0);
    rst_n = 1'b1;
    check("rel_fs",  32'(bus.frame_start), 32'h0);

    // First 40 states: frame_start for both widths, 1-digit anode timing,
    // and a load of 16'h1234 during state 5.
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check("fs",  32'(bus.frame_start), 32'(k == 1));
      check("fs1", 32'(bus1.frame_start), 32'(((k - 1) % 16) == 0));
      check("an1", 32'(bus1.an), 32'(((k - 1) % 16) < 2));
      if (k == 5) begin
        bus.value = 16'h1234;
        bus.load  = 1'b1;
      end
      if (k == 6) bus.load = 1'b0;
    end

    // Frame 0 still shows the reset contents.
    see(50);  check("f0_an3",  32'(bus.an), 32'b0111);
              check("f0_out3", 32'(bus.out), 32'b1000000);
    // Frame 1 shows 1234.
    see(64);  check("f1_fs",   32'(bus.frame_start), 32'h1);
              check("f1_gap0", 32'(bus.an), 32'hF);
    see(65);  check("f1_gap1", 32'(bus.an), 32'hF);
              check("f1_gapo", 32'(bus.out), 32'h7F);
    see(66);  check("f1_an0",  32'(bus.an), 32'b1110);
              check("f1_out0", 32'(bus.out), 32'b0011001);
    see(79);  check("f1_an0e", 32'(bus.an), 32'b1110);
              check("f1_dp0",  32'(bus.dp), 32'h1);
    see(82);  check("f1_an1",  32'(bus.an), 32'b1101);
              check("f1_out1", 32'(bus.out), 32'b0110000);
    see(98);  check("f1_an2",  32'(bus.an), 32'b1011);
              check("f1_out2", 32'(bus.out), 32'b0100100);
    see(114); check("f1_an3",  32'(bus.an), 32'b0111);
              check("f1_out3", 32'(bus.out), 32'b1111001);

    // brightness = 1: lit only on q == 0 (p = 2, 6, 10, 14).
    at_state(120); bus.brightness = 2'd1;
    see(130); check("pwm_p2",  32'(bus.an), 32'b1110);
    see(131); check("pwm_p3",  32'(bus.an), 32'hF);
    see(133); check("pwm_p5",  32'(bus.an), 32'hF);
    see(134); check("pwm_p6",  32'(bus.an), 32'b1110);
    see(142); check("pwm_p14", 32'(bus.an), 32'b1110);
    at_state(143); bus.brightness = 2'd0;
    see(146); check("dark_p2", 32'(bus.an), 32'hF);
    see(150); check("dark_p6", 32'(bus.an), 32'hF);
    at_state(180); bus.brightness = 2'd3;

    // Leading-zero blanking on 0050, shown in frame 4.
    at_state(190); bus.lz_en = 1'b1;
    load_at(200, 16'h0050, 4'b0000);
    see(258); check("lz_an0",  32'(bus.an), 32'b1110);
              check("lz_out0", 32'(bus.out), 32'b1000000);
    see(274); check("lz_an1",  32'(bus.an), 32'b1101);
              check("lz_out1", 32'(bus.out), 32'b0010010);
    see(293); check("lz_an2",  32'(bus.an), 32'hF);
    see(319); check("lz_an3",  32'(bus.an), 32'hF);

    // dp on digit 3 unblanks digits 2 and 3 (frame 6).
    load_at(330, 16'h0050, 4'b1000);
    see(418); check("dp_an2",  32'(bus.an), 32'b1011);
              check("dp_out2", 32'(bus.out), 32'b1000000);
              check("dp_dp2",  32'(bus.dp), 32'h1);
    see(432); check("dp_gapa", 32'(bus.an), 32'hF);
              check("dp_gapd", 32'(bus.dp), 32'h1);
    see(434); check("dp_an3",  32'(bus.an), 32'b0111);
              check("dp_dp3",  32'(bus.dp), 32'h0);

    // Tear-free: AAAA then BBBB inside frame 7, only B in frame 8.
    at_state(450); bus.lz_en = 1'b0;
    load_at(460, 16'hAAAA, 4'b0000);
    see(466); check("tf_hold", 32'(bus.out), 32'b0010010);
              check("tf_hola", 32'(bus.an), 32'b1101);
    load_at(470, 16'hBBBB, 4'b0000);
    see(514); check("tf_b0",   32'(bus.out), 32'b0000011);
              check("tf_b0an", 32'(bus.an), 32'b1110);
    // A pending 9999 is overridden by a load in the frame-end cycle.
    load_at(530, 16'h9999, 4'b0000);
    see(562); check("tf_b3",   32'(bus.out), 32'b0000011);
              check("tf_b3dp", 32'(bus.dp), 32'h1);
    load_at(575, 16'hC0DE, 4'b0000);
    see(578); check("fe_d0",   32'(bus.out), 32'b0000110);
    see(594); check("fe_d1",   32'(bus.out), 32'b0100001);
    see(626); check("fe_d3",   32'(bus.out), 32'b1000110);
              check("fe_an3",  32'(bus.an), 32'b0111);

    // Queue 7777, then reset asynchronously at p = 7, idx = 2.
    load_at(660, 16'h7777, 4'b0000);
    at_state(679);
    check("pre_an",  32'(bus.an), 32'b1011);
    check("pre_out", 32'(bus.out), 32'b1000000);
    #1 rst_n = 1'b0;
    #1;
    check("ar_out", 32'(bus.out), 32'h7F);
    check("ar_an",  32'(bus.an), 32'hF);
    check("ar_dp",  32'(bus.dp), 32'h1);
    check("ar_fs",  32'(bus.frame_start), 32'h0);
    check("ar_an1", 32'(bus1.an), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    at_state(1); check("rr_fs1", 32'(bus.frame_start), 32'h1);
    at_state(2); check("rr_fs2", 32'(bus.frame_start), 32'h0);
    see(2);      check("rr_an",  32'(bus.an), 32'b1110);
                 check("rr_out", 32'(bus.out), 32'b1000000);
    // Pending 7777 was discarded: frame 1 still shows zeros.
    see(66);     check("rr_pend", 32'(bus.out), 32'b1000000);
                 check("rr_an66", 32'(bus.an), 32'b1110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
